// File: rtl/alu_result_sel_pipe.sv
// Registered ALU result select stage.
// Muxes one of NUM_IN results by select code and hands it to writeback
// through a valid/ready interface. The interface is backed by a main
// register plus a skid register, so throughput stays full under backpressure.
// Out-of-range selects are passed on as zero data and raise a sticky error.
// A wrapping counter records completed output handshakes for debug.
module alu_result_sel_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 16,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr,
  output logic [CNT_W-1:0]        xfer_cnt
);

  // Buffer occupancy: EMPTY (nothing held), ONE (main full), TWO (main and skid full)
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, skid_data_q;
  logic [SEL_W-1:0]   main_sel_q, skid_sel_q;
  logic               out_valid_q, in_ready_q;
  logic               sel_err_q, sel_err_d;
  logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;

  logic               accept_c, drain_c;
  logic               load_main_c, load_skid_c, move_skid_c;
  logic [WIDTH-1:0]   sel_data_c;
  logic               sel_legal_c;

  assign accept_c = in_valid && in_ready_q;
  assign drain_c  = out_valid_q && out_ready;

  // Result mux; an out-of-range select yields zero and flags illegal
  always_comb begin
    sel_data_c  = '0;
    sel_legal_c = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (32'(in_sel) == k) begin
        sel_data_c  = in_data[k*WIDTH +: WIDTH];
        sel_legal_c = 1'b1;
      end
    end
  end

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next state from accept and downstream ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept_c) state_d = ST_ONE;
      ST_ONE: begin
        if (accept_c && !out_ready)      state_d = ST_TWO;
        else if (!accept_c && out_ready) state_d = ST_EMPTY;
      end
      ST_TWO:   if (out_ready) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Buffer load/move controls per occupancy state
  always_comb begin
    load_main_c = 1'b0;
    load_skid_c = 1'b0;
    move_skid_c = 1'b0;
    case (state_q)
      ST_EMPTY: load_main_c = accept_c;
      ST_ONE: begin
        load_main_c = accept_c && out_ready;
        load_skid_c = accept_c && !out_ready;
      end
      ST_TWO:   move_skid_c = out_ready;
      default: begin
        load_main_c = 1'b0;
      end
    endcase
  end

  // Sticky error (set beats clear) and wrapping handshake counter
  always_comb begin
    sel_err_d  = (accept_c && !sel_legal_c) || (sel_err_q && !err_clr);
    xfer_cnt_d = xfer_cnt_q + CNT_W'(drain_c);
  end

  // Datapath, handshake flags and debug registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      sel_err_q   <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      if (load_main_c) begin
        main_data_q <= sel_data_c;
        main_sel_q  <= in_sel;
      end else if (move_skid_c) begin
        main_data_q <= skid_data_q;
        main_sel_q  <= skid_sel_q;
      end
      if (load_skid_c) begin
        skid_data_q <= sel_data_c;
        skid_sel_q  <= in_sel;
      end
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_TWO);
      sel_err_q   <= sel_err_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign sel_err   = sel_err_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Bench for alu_result_sel_pipe: instance A (16 inputs, 16-bit counter)
// and instance B (12 inputs, 4-bit counter) checked against a FIFO model.
module tb_alu_result_sel_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A signals
  logic [511:0] in_data_a;
  logic [3:0]   in_sel_a;
  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [31:0]  out_data_a;
  logic [3:0]   out_sel_a;
  logic         sel_err_a, err_clr_a;
  logic [15:0]  xfer_cnt_a;

  // Instance B signals
  logic [383:0] in_data_b;
  logic [3:0]   in_sel_b;
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [31:0]  out_data_b;
  logic [3:0]   out_sel_b;
  logic         sel_err_b, err_clr_b;
  logic [3:0]   xfer_cnt_b;

  logic [31:0] w_a [16];
  logic [31:0] w_b [12];

  always_comb begin
    for (int k = 0; k < 16; k++) in_data_a[k*32 +: 32] = w_a[k];
    for (int k = 0; k < 12; k++) in_data_b[k*32 +: 32] = w_b[k];
  end

  alu_result_sel_pipe #(.WIDTH(32), .NUM_IN(16), .SEL_W(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_sel(in_sel_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .out_data(out_data_a),
    .out_sel(out_sel_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .sel_err(sel_err_a), .err_clr(err_clr_a), .xfer_cnt(xfer_cnt_a)
  );

  alu_result_sel_pipe #(.WIDTH(32), .NUM_IN(12), .SEL_W(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_sel(in_sel_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_sel(out_sel_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .sel_err(sel_err_b), .err_clr(err_clr_b), .xfer_cnt(xfer_cnt_b)
  );

  // Reference model: each accepted item waits in a FIFO until handed off
  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
  } item_t;

  item_t       q_a[$];
  item_t       q_b[$];
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic        err_a, err_b;
  int          hs_b_total;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    cnt_a = '0;
    cnt_b = '0;
    err_a = 1'b0;
    err_b = 1'b0;
    hs_b_total = 0;
  endtask

  // Compare both DUTs with the model, advance the model, then step one clock
  task automatic tick();
    item_t it;
    logic  acc, hs;
    chk("a_in_ready", 64'(in_ready_a), 64'(q_a.size() < 2));
    chk("a_out_valid", 64'(out_valid_a), 64'(q_a.size() > 0));
    if (q_a.size() > 0) begin
      chk("a_out_data", 64'(out_data_a), 64'(q_a[0].d));
      chk("a_out_sel", 64'(out_sel_a), 64'(q_a[0].s));
    end
    chk("a_sel_err", 64'(sel_err_a), 64'(err_a));
    chk("a_xfer_cnt", 64'(xfer_cnt_a), 64'(cnt_a));
    acc  = in_valid_a && (q_a.size() < 2);
    hs   = out_ready_a && (q_a.size() > 0);
    it.s = in_sel_a;
    it.d = w_a[in_sel_a];
    if (hs) begin
      void'(q_a.pop_front());
      cnt_a = cnt_a + 16'd1;
    end
    if (acc) q_a.push_back(it);
    if (err_clr_a) err_a = 1'b0;

    chk("b_in_ready", 64'(in_ready_b), 64'(q_b.size() < 2));
    chk("b_out_valid", 64'(out_valid_b), 64'(q_b.size() > 0));
    if (q_b.size() > 0) begin
      chk("b_out_data", 64'(out_data_b), 64'(q_b[0].d));
      chk("b_out_sel", 64'(out_sel_b), 64'(q_b[0].s));
    end
    chk("b_sel_err", 64'(sel_err_b), 64'(err_b));
    chk("b_xfer_cnt", 64'(xfer_cnt_b), 64'(cnt_b));
    acc  = in_valid_b && (q_b.size() < 2);
    hs   = out_ready_b && (q_b.size() > 0);
    it.s = in_sel_b;
    it.d = (in_sel_b < 4'd12) ? w_b[in_sel_b] : 32'd0;
    if (hs) begin
      void'(q_b.pop_front());
      cnt_b = cnt_b + 4'd1;
      hs_b_total++;
    end
    if (acc) q_b.push_back(it);
    if (acc && in_sel_b >= 4'd12) err_b = 1'b1;
    else if (err_clr_b)           err_b = 1'b0;

    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic        v;
    logic        r;
    logic        ov;
    logic [31:0] d;
    logic [3:0]  s;
    logic        ir;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected state after each cycle of a single/backpressure sequence on A
    tbl[0] = '{4'd5, 1'b1, 1'b1, 1'b1, 32'h1000_0005, 4'd5, 1'b1, 16'd0};
    tbl[1] = '{4'd0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 1'b1, 16'd1};
    tbl[2] = '{4'd2, 1'b1, 1'b0, 1'b1, 32'h1000_0002, 4'd2, 1'b1, 16'd1};
    tbl[3] = '{4'd3, 1'b1, 1'b0, 1'b1, 32'h1000_0002, 4'd2, 1'b0, 16'd1};
    tbl[4] = '{4'd4, 1'b1, 1'b0, 1'b1, 32'h1000_0002, 4'd2, 1'b0, 16'd1};
    tbl[5] = '{4'd4, 1'b1, 1'b1, 1'b1, 32'h1000_0003, 4'd3, 1'b1, 16'd2};
    tbl[6] = '{4'd4, 1'b1, 1'b1, 1'b1, 32'h1000_0004, 4'd4, 1'b1, 16'd3};
    tbl[7] = '{4'd0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 1'b1, 16'd4};

    for (int k = 0; k < 16; k++) w_a[k] = 32'h1000_0000 + 32'(k);
    for (int k = 0; k < 12; k++) w_b[k] = 32'h2000_0000 + 32'(k);
    in_sel_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b0; err_clr_a = 1'b0;
    in_sel_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b0; err_clr_b = 1'b0;
    model_reset();

    // Reset values while reset is held
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_out_data", 64'(out_data_a), 64'd0);
    chk("rst_out_sel", 64'(out_sel_a), 64'd0);
    chk("rst_in_ready", 64'(in_ready_a), 64'd1);
    chk("rst_sel_err", 64'(sel_err_b), 64'd0);
    chk("rst_xfer_cnt", 64'(xfer_cnt_a), 64'd0);
    rst = 1'b0;

    // Single transfer and backpressure table on A
    for (int i = 0; i < 8; i++) begin
      in_sel_a = tbl[i].sel; in_valid_a = tbl[i].v; out_ready_a = tbl[i].r;
      tick();
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid_a), 64'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_out_data", i), 64'(out_data_a), 64'(tbl[i].d));
        chk($sformatf("tbl%0d_out_sel", i), 64'(out_sel_a), 64'(tbl[i].s));
      end
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready_a), 64'(tbl[i].ir));
      chk($sformatf("tbl%0d_xfer_cnt", i), 64'(xfer_cnt_a), 64'(tbl[i].cnt));
    end

    // Back-to-back stream of all selects with no backpressure
    out_ready_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_sel_a = 4'(i); in_valid_a = 1'b1;
      tick();
      chk("stream_in_ready", 64'(in_ready_a), 64'd1);
      chk("stream_out_data", 64'(out_data_a), 64'(32'h1000_0000 + 32'(i)));
    end
    in_valid_a = 1'b0;
    tick();
    chk("stream_xfer_cnt", 64'(xfer_cnt_a), 64'd20);

    // Illegal select on B, error clear, and set-beats-clear
    in_sel_b = 4'd13; in_valid_b = 1'b1; out_ready_b = 1'b1;
    tick();
    chk("b_illegal_data", 64'(out_data_b), 64'd0);
    chk("b_illegal_sel", 64'(out_sel_b), 64'd13);
    chk("b_illegal_err", 64'(sel_err_b), 64'd1);
    in_valid_b = 1'b0; err_clr_b = 1'b1;
    tick();
    chk("b_err_cleared", 64'(sel_err_b), 64'd0);
    in_sel_b = 4'd14; in_valid_b = 1'b1;
    tick();
    chk("b_err_set_wins", 64'(sel_err_b), 64'd1);
    in_valid_b = 1'b0; err_clr_b = 1'b0;
    tick();

    // Random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      in_sel_a    = 4'($urandom_range(0, 15));
      in_valid_a  = 1'($urandom_range(0, 1));
      out_ready_a = 1'($urandom_range(0, 3) != 0);
      in_sel_b    = 4'($urandom_range(0, 15));
      in_valid_b  = 1'($urandom_range(0, 1));
      out_ready_b = 1'($urandom_range(0, 1));
      err_clr_b   = 1'($urandom_range(0, 7) == 0);
      err_clr_a   = 1'($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) w_a[$urandom_range(0, 15)] = $urandom;
      if ($urandom_range(0, 3) == 0) w_b[$urandom_range(0, 11)] = $urandom;
      tick();
    end
    in_valid_b = 1'b0; err_clr_b = 1'b0; err_clr_a = 1'b0;

    // Fill A to two entries, then reset asynchronously mid-cycle
    out_ready_a = 1'b0; in_valid_a = 1'b1; in_sel_a = 4'd7;
    for (int i = 0; i < 6 && q_a.size() < 2; i++) tick();
    chk("pre_reset_full", 64'(in_ready_a), 64'd0);
    in_valid_a = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("async_out_valid", 64'(out_valid_a), 64'd0);
    chk("async_in_ready", 64'(in_ready_a), 64'd1);
    chk("async_sel_err", 64'(sel_err_b), 64'd0);
    chk("async_xfer_cnt_a", 64'(xfer_cnt_a), 64'd0);
    chk("async_xfer_cnt_b", 64'(xfer_cnt_b), 64'd0);
    model_reset();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    in_sel_a = 4'd9; in_valid_a = 1'b1; out_ready_a = 1'b1;
    tick();
    chk("post_reset_data", 64'(out_data_a), 64'(w_a[9]));
    in_valid_a = 1'b0;
    tick();
    chk("post_reset_drained", 64'(out_valid_a), 64'd0);

    // Counter wrap on B's 4-bit counter
    in_valid_b = 1'b1; out_ready_b = 1'b1;
    for (int i = 0; i < 40 && hs_b_total < 17; i++) begin
      in_sel_b = 4'($urandom_range(0, 11));
      tick();
      if (hs_b_total == 15) chk("wrap_15", 64'(xfer_cnt_b), 64'd15);
      if (hs_b_total == 16) chk("wrap_16", 64'(xfer_cnt_b), 64'd0);
      if (hs_b_total == 17) chk("wrap_17", 64'(xfer_cnt_b), 64'd1);
    end
    chk("wrap_reached", 64'(hs_b_total >= 17), 64'd1);
    in_valid_b = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_sel_pipe.md
Name: alu_result_sel_pipe

Overview:
- Parametrised, registered successor to the ALU result multiplexer.
- Selects one of NUM_IN WIDTH-bit functional-unit results by a select code and registers the result.
- Carries the result to the writeback stage over a valid/ready handshake.
- A 2-entry output buffer (main + skid) gives full throughput under backpressure.
- Adds illegal-select detection and a transfer counter for debug.

Parameters:
- WIDTH, 32, data width of every input and the output.
- NUM_IN, 16, number of result inputs; legal range 2..64.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= NUM_IN.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  select code; k selects input k.
- in_valid  input  1  upstream offers in_data/in_sel this cycle.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  registered selected result.
- out_sel  output  SEL_W  select code that produced out_data.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  downstream accepts this cycle.
- sel_err  output  1  sticky flag: an out-of-range select was accepted.
- err_clr  input  1  clears sel_err.
- xfer_cnt  output  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (async assert, sync to clk on release): out_data=0, out_sel=0, out_valid=0, sel_err=0, xfer_cnt=0, skid empty; in_ready=1 while and after reset.
- Accept: in_valid && in_ready at a rising edge. Output handshake: out_valid && out_ready at a rising edge.
- Select function: data = input[in_sel] if in_sel < NUM_IN.
  - Otherwise data = 0 and the error condition fires.
  - X is never propagated.
- Latency: 1 cycle. Data accepted at edge N appears on out_data after edge N when the main register is empty or draining.
- State, per main/skid occupancy:
  - EMPTY (main empty, skid empty):
    - accept -> ONE; main loads.
  - ONE (main full, skid empty):
    - accept with out_ready=1 -> ONE; main reloads.
    - accept with out_ready=0 -> TWO; skid loads, main holds.
    - out_ready=1 with no accept -> EMPTY.
    - otherwise hold.
  - TWO (main full, skid full):
    - in_ready=0.
    - out_ready=1 -> ONE; skid moves to main.
- in_ready = !skid_full. It is purely a function of registered state, never of out_ready combinationally.
- out_data/out_sel must stay stable while out_valid=1 and out_ready=0.
- Ordering: strictly FIFO; no accepted transaction is dropped or duplicated.
- sel_err:
  - Set on the edge that accepts an out-of-range in_sel.
  - Cleared by err_clr=1.
  - If set and clear occur on the same edge, set wins.
  - An out-of-range select is still transferred as data 0 with its out_sel preserved.
- xfer_cnt:
  - Increments by 1 per output handshake.
  - Wraps from 2**CNT_W-1 to 0.
  - Unaffected by err_clr.
- Reset mid-operation: buffered transactions are discarded and all state returns to reset values immediately.
- When NUM_IN is a power of two and 2**SEL_W == NUM_IN, the error path is unreachable; sel_err stays 0.

Test Plan:
- Reset, then input k = 0x1000_0000+k for all 16 inputs, in_sel=5, in_valid 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=0x1000_0005, out_sel=5; following cycle out_valid=0; xfer_cnt=1.
- Stream in_sel 0..15 back-to-back with out_ready=1 -> in_ready stays 1; outputs 0x1000_0000..0x1000_000F on consecutive cycles in order; xfer_cnt=16.
- Backpressure: out_ready=0, send sel 2 then 3 ->
  - Main holds 0x1000_0002 and skid holds sel 3; in_ready=0 after the second accept; a third offer (sel 4) waits.
  - Raise out_ready -> outputs 2, 3, 4 in order, with no loss or duplication.
- NUM_IN=12, SEL_W=4, in_sel=13 accepted -> out_data=0, out_sel=13, sel_err=1.
  - err_clr pulse -> sel_err=0.
  - err_clr and a new sel=14 accept on the same edge -> sel_err=1.
- CNT_W=4: complete 17 output handshakes -> xfer_cnt reads 15 after 15, 0 after 16, 1 after 17.
- Assert rst asynchronously (mid-cycle) while in state TWO -> out_valid=0, in_ready=1, sel_err=0, xfer_cnt=0 immediately; after release the first accept yields only the new data.
